// File: rtl/ps2_klavye_alici.sv
// PS/2 keyboard receiver: synchronizes and filters the raw PS/2 pins,
// deframes 11-bit device-to-host frames, drops break/extended sequences
// and strobes each make code out to the password checker.
module ps2_klavye_alici #(
  parameter int FILTRE_LEN  = 4,
  parameter int ZAMAN_ASIMI = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] karakter,
  output logic       karakter_aktif,
  output logic       parite_hata,
  output logic       cerceve_hata
);

  localparam int FW = (FILTRE_LEN > 1) ? $clog2(FILTRE_LEN + 1) : 1;
  localparam int TW = $clog2(ZAMAN_ASIMI + 1);

  localparam logic [7:0] KOD_BIRAK = 8'hF0;
  localparam logic [7:0] KOD_GENIS = 8'hE0;

  typedef enum logic [1:0] {BOSTA, VERI, PARITE, DUR} durum_t;

  // index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0] pin_ham;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;

  logic          filt_seviye_reg;
  logic [FW-1:0] filt_sayac_reg;
  logic          kenar_reg;

  durum_t        durum_reg;
  logic [7:0]    kaydirma_reg;
  logic [2:0]    bit_sayac_reg;
  logic          parite_reg;
  logic [TW-1:0] zaman_reg;
  logic          birak_reg;

  logic          veri_bit;
  logic          parite_dogru;

  assign pin_ham      = {ps2_data, ps2_clk};
  assign veri_bit     = sync2_reg[1];
  assign parite_dogru = ^{kaydirma_reg, parite_reg};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      // two-stage synchronizer per pin, idle level is high
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg[gi] <= 1'b1;
          sync2_reg[gi] <= 1'b1;
        end else begin
          sync1_reg[gi] <= pin_ham[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  // glitch filter on the clock pin; kenar pulses on a filtered 1->0 change
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_seviye_reg <= 1'b1;
      filt_sayac_reg  <= '0;
      kenar_reg       <= 1'b0;
    end else begin
      kenar_reg <= 1'b0;
      if (sync2_reg[0] != filt_seviye_reg) begin
        if (filt_sayac_reg == FW'(FILTRE_LEN - 1)) begin
          filt_seviye_reg <= sync2_reg[0];
          filt_sayac_reg  <= '0;
          kenar_reg       <= filt_seviye_reg;
        end else begin
          filt_sayac_reg <= filt_sayac_reg + 1'b1;
        end
      end else begin
        filt_sayac_reg <= '0;
      end
    end
  end

  // frame FSM, timeout watchdog and scan-code decoder with registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      durum_reg      <= BOSTA;
      kaydirma_reg   <= '0;
      bit_sayac_reg  <= '0;
      parite_reg     <= 1'b0;
      zaman_reg      <= '0;
      birak_reg      <= 1'b0;
      karakter       <= 8'h00;
      karakter_aktif <= 1'b0;
      parite_hata    <= 1'b0;
      cerceve_hata   <= 1'b0;
    end else begin
      karakter_aktif <= 1'b0;
      parite_hata    <= 1'b0;
      cerceve_hata   <= 1'b0;

      if (kenar_reg) begin
        zaman_reg <= '0;
        case (durum_reg)
          BOSTA: begin
            // a high data bit here is not a start bit; ignore the edge
            if (!veri_bit) begin
              bit_sayac_reg <= '0;
              durum_reg     <= VERI;
            end
          end
          VERI: begin
            kaydirma_reg <= {veri_bit, kaydirma_reg[7:1]};
            if (bit_sayac_reg == 3'd7) begin
              durum_reg <= PARITE;
            end else begin
              bit_sayac_reg <= bit_sayac_reg + 3'd1;
            end
          end
          PARITE: begin
            parite_reg <= veri_bit;
            durum_reg  <= DUR;
          end
          DUR: begin
            durum_reg <= BOSTA;
            if (!parite_dogru) begin
              parite_hata <= 1'b1;
            end else if (!veri_bit) begin
              cerceve_hata <= 1'b1;
            end else if (kaydirma_reg == KOD_BIRAK) begin
              birak_reg <= 1'b1;
            end else if (kaydirma_reg == KOD_GENIS) begin
              // extended prefix carries no key identity of its own
            end else if (birak_reg) begin
              birak_reg <= 1'b0;
            end else begin
              karakter       <= kaydirma_reg;
              karakter_aktif <= 1'b1;
            end
          end
          default: durum_reg <= BOSTA;
        endcase
      end else if (durum_reg != BOSTA) begin
        if (zaman_reg == TW'(ZAMAN_ASIMI - 1)) begin
          durum_reg    <= BOSTA;
          kaydirma_reg <= '0;
          zaman_reg    <= '0;
          cerceve_hata <= 1'b1;
        end else begin
          zaman_reg <= zaman_reg + 1'b1;
        end
      end else begin
        zaman_reg <= '0;
      end
    end
  end

endmodule

// File: doc/ps2_klavye_alici.md
# ps2_klavye_alici

PS/2 keyboard receiver feeding the `klavye_dinle` password checker. It samples the raw `ps2_clk`/`ps2_data` pins and deframes 11-bit device-to-host frames. Key-release (break) sequences and extended prefixes are filtered out. For every make code it presents an 8-bit scan code on `karakter` together with a one-cycle `karakter_aktif` strobe, which connect directly to the checker's `karakter` and `karakter_aktif` inputs.

## Interface
- `FILTRE_LEN`, default 4: consecutive equal samples required before the filtered PS/2 clock changes level.
- `ZAMAN_ASIMI`, default 200000: clock cycles without a falling edge that abort a partial frame (2 ms at 100 MHz).
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: **one clock; reset is synchronous and active-high.**
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `karakter` out 8: last accepted make scan code. Held between strobes.
- `karakter_aktif` out 1: one-cycle strobe, high when `karakter` is new.
- `parite_hata` out 1: one-cycle strobe on a parity error.
- `cerceve_hata` out 1: one-cycle strobe on a stop-bit error or a timeout abort.

## Operation
- **Input conditioning**
  - Each pin passes through a 2-FF synchronizer, with both stages reset to 1.
  - `ps2_clk` is then filtered. The filtered level is reset to 1 and changes only after `FILTRE_LEN` consecutive synchronized samples of the opposite level.
  - `kenar` is a 1-cycle pulse marking a filtered 1→0 transition. `ps2_data` is sampled (synchronized) in the cycle `kenar` is high.
- **Frame FSM.** States are BOSTA, VERI, PARITE, DUR.
  - BOSTA: on `kenar` with data=0 (start bit), clear the bit counter and go to VERI. On `kenar` with data=1, stay in BOSTA and discard the edge.
  - VERI: on each `kenar`, shift data in LSB first. After the 8th bit, go to PARITE.
  - PARITE: on `kenar`, store the parity bit and go to DUR.
  - DUR: on `kenar`, validate and return to BOSTA.
    - Odd parity means data bits plus parity bit contain an odd number of 1s. If parity is wrong, pulse `parite_hata`.
    - Otherwise, if the stop bit is 0, pulse `cerceve_hata`.
    - Otherwise the frame is good and is passed to the code decoder.
    - A bad frame produces no `karakter_aktif` and leaves the break flag untouched.
- **Timeout.** A counter is cleared on every `kenar` and in BOSTA. In any other state, reaching `ZAMAN_ASIMI`-1 forces BOSTA, discards the shift register and pulses `cerceve_hata`.
- **Code decoder.** Acts on good frames only.
  - 0xF0: set the break flag. No output.
  - 0xE0: swallowed. The break flag is unchanged and there is no output.
  - Any other code with the break flag set: clear the flag. No output (release event).
  - Any other code with the break flag clear: load `karakter` and pulse `karakter_aktif`.
- **Reset.** Applies in any state, including mid-frame.
  - FSM goes to BOSTA. Shift register, bit counter, timeout counter and break flag are cleared.
  - `karakter`=8'h00, `karakter_aktif`=0, `parite_hata`=0, `cerceve_hata`=0.
  - No strobe may be emitted in the cycle after reset deasserts.
- **Repeats.** Typematic repeats of the same make code produce one strobe per frame; no deduplication.

## Timing
- Pin-to-edge latency: a falling edge on `ps2_clk` produces `kenar` 2 (sync) + `FILTRE_LEN` cycles later, ±1 cycle.
- If the stop-bit `kenar` is high in cycle N, `karakter`, `karakter_aktif`, `parite_hata` and `cerceve_hata` update in cycle N+1. Strobes are high for exactly that one cycle.
- `karakter` changes only in a cycle where `karakter_aktif`=1.
- At most one of the three strobes is high in any cycle.
- Timeout abort: `cerceve_hata` is high for exactly the cycle after the counter reaches its limit.
- `rst` has priority over `kenar`, timeout and strobe generation in the same cycle.
- Sustained rate: one frame per 11 `kenar` pulses. No back-pressure, because the downstream checker accepts a strobe every cycle.

## Test plan
- Send a clean frame for 0x1C (parity bit 0, stop 1) at a 60 µs bit period → `karakter`=8'h1C with a single `karakter_aktif` pulse one cycle after the stop-bit `kenar`; error strobes stay 0.
- Send F0, then 1C, then 1C → no strobe for the first two frames; the third gives `karakter`=8'h1C with one pulse. The break flag is clear afterwards.
- Send 0x1C with the parity bit flipped → `parite_hata` pulses once, no `karakter_aktif`, and `karakter` keeps its previous value. Then send 0x24 correctly → `karakter`=8'h24.
- Send a start bit plus 4 data bits, then stop toggling → `cerceve_hata` pulses `ZAMAN_ASIMI` cycles after the last edge and the FSM is in BOSTA. A following 0x32 frame yields `karakter`=8'h32.
- Send E0, then 75 → `karakter`=8'h75 with one pulse. Send E0, F0, 75 → no strobe.
- Put a `ps2_clk` low glitch of `FILTRE_LEN`-1 cycles in BOSTA → no `kenar` and no state change. Assert `rst` for 1 cycle after the 6th bit of a frame → all outputs 0 and the FSM in BOSTA; the remainder of the interrupted frame (data bits start with 1) is discarded with no strobe.
